// File: rtl/hamming_pkg.sv
// Shared widths and FSM encoding for the Hamming(7,4) transmit scheduler.
package hamming_pkg;

    localparam int DATA_W = 4;
    localparam int CODE_W = 7;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } state_e;

endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(7,4) encoder: parity bits at c0, c1, c3; data at c2, c4, c5, c6.
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    always_comb begin
        code_o[0] = data_i[0] ^ data_i[1] ^ data_i[3];
        code_o[1] = data_i[0] ^ data_i[2] ^ data_i[3];
        code_o[2] = data_i[0];
        code_o[3] = data_i[1] ^ data_i[2] ^ data_i[3];
        code_o[4] = data_i[1];
        code_o[5] = data_i[2];
        code_o[6] = data_i[3];
    end

endmodule

// File: rtl/hamming_tx_scheduler.sv
// Round-robin scheduler feeding NREQ byte requesters through one Hamming(7,4)
// encoder; each granted byte leaves as two codewords, low nibble first.
module hamming_tx_scheduler
    import hamming_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*BYTE_W-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CODE_W-1:0]         out_code,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic                      out_last,
    output logic                      busy,
    output logic [1:0]                dbg_state_o
);

    localparam int IDW = $clog2(NREQ);

    // Handshakes: a byte moves when req_valid[i] && req_ready[i]; a codeword
    // moves when out_valid && out_ready. Once out_valid rises, out_code,
    // out_id and out_last stay stable until that transfer happens.

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                last_q, last_d;

    logic                gnt_found;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW:0]        cand;
    logic [BYTE_W-1:0]   gnt_byte;
    logic [DATA_W-1:0]   enc_in;
    logic [CODE_W-1:0]   enc_out;

    // First valid requester at or above rr_ptr_q, wrapping past NREQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        gnt_byte = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_idx == IDW'(r)) begin
                gnt_byte = req_data[r*BYTE_W +: BYTE_W];
            end
        end
    end

    // The single encoder sees the incoming low nibble while idle and the
    // captured high nibble afterwards.
    assign enc_in = (state_q == ST_IDLE) ? gnt_byte[DATA_W-1:0]
                                         : byte_q[BYTE_W-1:DATA_W];

    hamming_encoder u_encoder (
        .data_i (enc_in),
        .code_o (enc_out)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        byte_d    = byte_q;
        id_d      = id_q;
        code_d    = code_q;
        last_d    = last_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    req_ready[gnt_idx] = 1'b1;
                    byte_d  = gnt_byte;
                    id_d    = gnt_idx;
                    code_d  = enc_out;
                    last_d  = 1'b0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (out_ready) begin
                    code_d  = enc_out;
                    last_d  = 1'b1;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            byte_q   <= '0;
            id_q     <= '0;
            code_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            byte_q   <= byte_d;
            id_q     <= id_d;
            code_q   <= code_d;
            last_q   <= last_d;
        end
    end

    assign out_valid   = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign out_code    = code_q;
    assign out_id      = id_q;
    assign out_last    = last_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hamming_tx_scheduler.sv
// Self-checking bench for hamming_tx_scheduler: a round-robin reference model
// predicts grants and codewords into a queue that the output monitor drains.
`timescale 1ns/1ps
module tb_hamming_tx_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [6:0]        out_code;
    logic [1:0]        out_id;
    logic              out_last;
    logic              busy;
    logic [1:0]        dbg_state;

    hamming_tx_scheduler #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .out_id      (out_id),
        .out_last    (out_last),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   obs_q[$];
    logic [7:0]     src_mem[NREQ][0:299];
    int             src_rd[NREQ];
    int             src_wr[NREQ];
    int             rdy_cnt[NREQ];
    logic [NREQ-1:0] flash_mask = '0;
    logic [7:0]     flash_data = '0;
    logic           rand_ready = 1'b0;
    logic           ready_hold = 1'b1;
    int             m_state = 0;
    int             m_rr = 0;
    int             m_id = 0;
    int             t2_ids[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc_ref(input logic [3:0] d);
        return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    endfunction

    function automatic logic [W-1:0] obs_at(input int k);
        if (k < obs_q.size()) return obs_q[k];
        return '1;
    endfunction

    task automatic enqueue(input int r, input logic [7:0] b);
        src_mem[r][src_wr[r]] = b;
        src_wr[r]++;
    endtask

    task automatic wait_drain(input int budget);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            #1;
            done = (m_state == 0) && (exp_q.size() == 0);
            for (int r = 0; r < NREQ; r++) begin
                if (src_rd[r] != src_wr[r]) done = 0;
            end
            n++;
        end
        check_eq("drain", 32'(done), 32'd1);
    endtask

    task automatic wait_state(input int s, input int budget);
        int n;
        n = 0;
        while (int'(dbg_state) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_state", 32'(dbg_state), 32'(s));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester driver: each requester presents its buffered bytes in order.
    initial begin
        logic [NREQ-1:0] taken;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            taken = req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (taken[r] && src_rd[r] != src_wr[r]) src_rd[r]++;
                if (src_rd[r] != src_wr[r]) begin
                    req_valid[r] = 1'b1;
                    req_data[r*8 +: 8] = src_mem[r][src_rd[r]];
                end else if (flash_mask[r]) begin
                    req_valid[r] = 1'b1;
                    req_data[r*8 +: 8] = flash_data;
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
        end
    end

    // Reference model and output monitor.
    initial begin
        int          pick;
        int          idx;
        bit          found;
        logic [7:0]  b;
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_state = 0;
                m_rr    = 0;
                m_id    = 0;
            end else begin
                check_eq("out_valid", 32'(out_valid), 32'(m_state != 0));
                check_eq("busy", 32'(busy), 32'(m_state != 0));
                for (int r = 0; r < NREQ; r++) begin
                    if (req_ready[r]) rdy_cnt[r]++;
                end
                if (m_state == 0) begin
                    found = 0;
                    pick  = 0;
                    for (int i = 0; i < NREQ; i++) begin
                        idx = (m_rr + i) % NREQ;
                        if (!found && req_valid[idx]) begin
                            found = 1;
                            pick  = idx;
                        end
                    end
                    check_eq("req_ready", 32'(req_ready), found ? (32'd1 << pick) : 32'd0);
                    if (found) begin
                        b = req_data[pick*8 +: 8];
                        exp_q.push_back({2'(pick), 1'b0, enc_ref(b[3:0])});
                        exp_q.push_back({2'(pick), 1'b1, enc_ref(b[7:4])});
                        m_id    = pick;
                        m_state = 1;
                    end
                end else begin
                    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            check_eq("exp_q_empty", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("codeword", 32'({out_id, out_last, out_code}), 32'(e));
                            obs_q.push_back({out_id, out_last, out_code});
                        end
                        if (m_state == 1) begin
                            m_state = 2;
                        end else begin
                            m_state = 0;
                            m_rr    = (m_id == NREQ - 1) ? 0 : m_id + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int snap0;
        int snap1;

        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_out_code", 32'(out_code), 32'd0);
        check_eq("rst_out_id", 32'(out_id), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single byte 0xA5 from requester 0.
        base  = obs_q.size();
        snap0 = rdy_cnt[0];
        enqueue(0, 8'hA5);
        wait_drain(50);
        check_eq("t1_lo", 32'(obs_at(base)), 32'({2'd0, 1'b0, 7'h2D}));
        check_eq("t1_hi", 32'(obs_at(base + 1)), 32'({2'd0, 1'b1, 7'h52}));
        check_eq("t1_ready_pulses", 32'(rdy_cnt[0] - snap0), 32'd1);

        // All four requesters at once, requester 0 twice.
        do_reset();
        base = obs_q.size();
        enqueue(0, 8'h11);
        enqueue(1, 8'h22);
        enqueue(2, 8'h33);
        enqueue(3, 8'h44);
        enqueue(0, 8'h55);
        wait_drain(100);
        for (int k = 0; k < 10; k++) begin
            check_eq("t2_id", 32'(obs_at(base + k) >> 8), 32'(t2_ids[k]));
        end

        // Stall in LO with 0xFF from requester 2; others must wait or vanish.
        ready_hold = 1'b0;
        base = obs_q.size();
        enqueue(2, 8'hFF);
        wait_state(1, 20);
        snap0 = rdy_cnt[0];
        snap1 = rdy_cnt[1];
        enqueue(0, 8'h5A);
        flash_data = 8'hC3;
        flash_mask = 4'b0010;
        repeat (5) begin
            @(negedge clk);
            check_eq("t3_hold_code", 32'(out_code), 32'h7F);
            check_eq("t3_hold_last", 32'(out_last), 32'd0);
            check_eq("t3_hold_id", 32'(out_id), 32'd2);
        end
        check_eq("t3_no_ready0", 32'(rdy_cnt[0] - snap0), 32'd0);
        flash_mask = '0;
        ready_hold = 1'b1;
        wait_drain(60);
        check_eq("t3_id0", 32'(obs_at(base) >> 8), 32'd2);
        check_eq("t3_id2", 32'(obs_at(base + 2) >> 8), 32'd0);
        check_eq("t3_count", 32'(obs_q.size() - base), 32'd4);
        check_eq("t3_skip1", 32'(rdy_cnt[1] - snap1), 32'd0);

        // Requester 1 sends 0x00, then 0 and 2 collide with rr_ptr at 2.
        do_reset();
        base = obs_q.size();
        enqueue(1, 8'h00);
        wait_drain(50);
        check_eq("t4_lo", 32'(obs_at(base)), 32'({2'd1, 1'b0, 7'h00}));
        check_eq("t4_hi", 32'(obs_at(base + 1)), 32'({2'd1, 1'b1, 7'h00}));
        base = obs_q.size();
        enqueue(0, 8'h81);
        enqueue(2, 8'h18);
        wait_drain(60);
        check_eq("t4_first", 32'(obs_at(base) >> 8), 32'd2);
        check_eq("t4_second", 32'(obs_at(base + 2) >> 8), 32'd0);

        // Reset while holding the high-nibble codeword.
        ready_hold = 1'b0;
        enqueue(1, 8'h3C);
        wait_state(1, 20);
        ready_hold = 1'b1;
        @(posedge clk);
        #2 ready_hold = 1'b0;
        wait_state(2, 5);
        #1 rst = 1'b1;
        @(negedge clk);
        check_eq("t5_out_valid", 32'(out_valid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_state", 32'(dbg_state), 32'd0);
        check_eq("t5_out_code", 32'(out_code), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        ready_hold = 1'b1;
        base = obs_q.size();
        repeat (10) @(negedge clk);
        check_eq("t5_no_stale", 32'(obs_q.size() - base), 32'd0);
        enqueue(1, 8'h96);
        enqueue(0, 8'h69);
        wait_drain(60);
        check_eq("t5_rr_reset", 32'(obs_at(base) >> 8), 32'd0);

        // Every byte through requester 3 with random downstream stalls.
        rand_ready = 1'b1;
        base = obs_q.size();
        for (int v = 0; v < 256; v++) begin
            enqueue(3, 8'(v));
        end
        wait_drain(4000);
        rand_ready = 1'b0;
        check_eq("t6_count", 32'(obs_q.size() - base), 32'd512);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_tx_scheduler.md
HAMMING_TX_SCHEDULER -- requirements
Module: hamming_tx_scheduler

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters sharing one Hamming(7,4) encoder (2..8).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req_valid  input  NREQ  SHALL flag, per requester, a byte offered for encoding.
REQ-005 req_data  input  NREQ*8  SHALL carry requester i's byte at bits [8i+7:8i].
REQ-006 req_ready  output  NREQ  SHALL be one-hot or zero; high for one cycle when the granted requester's byte is captured.
REQ-007 out_valid  output  1  SHALL flag a valid codeword on out_code.
REQ-008 out_ready  input  1  SHALL be downstream acceptance; a transfer occurs when out_valid && out_ready.
REQ-009 out_code  output  7  SHALL be the Hamming(7,4) codeword of the current nibble.
REQ-010 out_id  output  $clog2(NREQ)  SHALL identify the requester owning out_code.
REQ-011 out_last  output  1  SHALL be high on the high-nibble codeword, low on the low-nibble codeword.
REQ-012 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, LO, HI.
REQ-014 In IDLE, if any req_valid is high, the block SHALL grant the first valid requester found searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... NREQ-1, 0, ...).
REQ-015 In IDLE, req_ready[g] SHALL be driven combinationally in the grant cycle; the byte, g and the low-nibble codeword SHALL be registered, and the FSM SHALL move to LO.
REQ-016 out_valid SHALL be high in LO and HI only; the first codeword SHALL appear the cycle after capture (latency 1).
REQ-017 In LO, on out_ready the FSM SHALL load the high-nibble codeword and move to HI; otherwise out_code/out_id/out_last SHALL hold.
REQ-018 In HI, on out_ready the FSM SHALL return to IDLE and set rr_ptr = (g+1) mod NREQ; otherwise outputs SHALL hold.
REQ-019 Grant SHALL be locked for both nibbles; no other requester is served until HI completes.
REQ-020 req_ready SHALL be zero in LO and HI regardless of req_valid.
REQ-021 Byte throughput SHALL be at most one byte per 3 cycles with out_ready held high.
REQ-022 A requester deasserting req_valid before grant SHALL be skipped without side effect.
REQ-023 Codeword bit mapping SHALL be: c0=d0^d1^d3, c1=d0^d2^d3, c2=d0, c3=d1^d2^d3, c4=d1, c5=d2, c6=d3.
REQ-024 rr_ptr SHALL change only on HI completion, wrapping NREQ-1 -> 0.

Reset
REQ-025 While rst is high: state=IDLE, rr_ptr=0, out_valid=0, out_code=0, out_id=0, out_last=0, busy=0, req_ready=0.
REQ-026 Reset asserted mid-transfer SHALL discard the in-flight byte; no further codeword for it SHALL be emitted.

Structure
REQ-027 Shared package hamming_pkg SHALL hold DATA_W=4, CODE_W=7, BYTE_W=8 and the FSM state enum.
REQ-028 Exactly one instance of sub-module hamming_encoder (4-bit in, 7-bit out) SHALL be used, its input muxed between low and high nibble of the captured byte.

Verification
REQ-029 Single requester 0 sends 0xA5, out_ready=1 -> out_code 0x2D (last=0) then 0x52 (last=1), out_id=0, req_ready[0] one pulse.
REQ-030 All four requesters valid, out_ready=1 -> grant order 0,1,2,3,0; each byte yields two codewords with correct out_id.
REQ-031 Requester 2 sends 0xFF, out_ready low 5 cycles in LO -> out_code holds 0x0F-nibble codeword 0x7F, out_last=0, no req_ready pulses meanwhile.
REQ-032 Requester 1 sends 0x00 -> 0x00, 0x00; rr_ptr then 2, so simultaneous requests on 0 and 2 grant 2 first.
REQ-033 Assert rst in HI state -> out_valid=0 next cycle, busy=0, rr_ptr=0, no HI codeword emitted after deassertion.
REQ-034 Exhaustive 0x00..0xFF through requester 3 -> every codeword matches REQ-023 reference model.
